// File: rtl/float_accum_ctrl.sv
// Purpose     : sequential accumulator wrapped around the external combinational minifloat adder.
// Latency     : operand accepted at cycle t -> next in_ready (or out_valid on the last one) at t+2+ADD_WAIT.
// Backpressure: in_ready only in ACC; the final sum is held on out_data/out_valid until out_ready.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start, count              run command (sampled only in IDLE) and operand count
//   in_data/in_valid/in_ready operand stream
//   add_a, add_b, add_result  running sum and registered operand to the adder, sum back
//   out_data/out_valid/out_ready  final sum handshake
//   busy                      high in every state except IDLE
//   sat_flag                  sticky saturation indicator, present only when FACC_SAT_FLAG_EN is defined
//
// Number format: [7:5] exponent, [4:0] mantissa, unsigned, no hidden bit.
// Optional feature macro: FACC_SAT_FLAG_EN (adds the sat_flag port and its logic).

module float_accum_ctrl #(
    parameter int CNT_W    = 4,
    parameter int ADD_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [7:0]       add_result,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef FACC_SAT_FLAG_EN
    output logic             sat_flag,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Hold-cycle counter is 3 bits wide, which bounds ADD_WAIT to 0..7.
    localparam logic [2:0] WAIT_INIT = ADD_WAIT[2:0];

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       b_reg_q, b_reg_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [2:0]       wait_q, wait_d;

    // Operand handshake completes only in ACC, so in_valid elsewhere is ignored.
    logic             in_fire;
    // Adder result is sampled once the hold window has elapsed.
    logic             add_capture;

    assign in_fire     = (state_q == S_ACC) && in_valid;
    assign add_capture = (state_q == S_ADD) && (wait_q == 3'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= 8'h00;
            b_reg_q     <= 8'h00;
            remaining_q <= '0;
            wait_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            b_reg_q     <= b_reg_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        b_reg_d     = b_reg_q;
        remaining_d = remaining_q;
        wait_d      = wait_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = 8'h00;
                    if (count != '0) begin
                        remaining_d = count;
                        state_d     = S_ACC;
                    end else begin
                        // Empty run: report the zero sum straight away.
                        state_d = S_DONE;
                    end
                end
            end

            S_ACC: begin
                if (in_fire) begin
                    b_reg_d = in_data;
                    wait_d  = WAIT_INIT;
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    acc_d       = add_result;
                    remaining_d = remaining_q - 1'b1;
                    // remaining is at least 1 here, so the decrement never wraps.
                    state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_ACC;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state or taken straight from registers
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            S_IDLE:  busy      = 1'b0;
            S_ACC:   in_ready  = 1'b1;
            S_ADD:   in_ready  = 1'b0;
            S_DONE:  out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // acc only changes in IDLE and ADD, so out_data is stable throughout DONE.
    assign out_data = acc_q;
    assign add_a    = acc_q;
    assign add_b    = b_reg_q;

`ifdef FACC_SAT_FLAG_EN
    logic sat_q, sat_d;

    // Sticky until the next accepted start; a saturated sum is 8'hFF.
    always_comb begin
        sat_d = sat_q;
        if (state_q == S_IDLE && start) begin
            sat_d = 1'b0;
        end else if (add_capture && add_result == 8'hFF) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`endif

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid));

endmodule
